// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter.
// State encoding for the APB phase machine.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    localparam int APB_N_DEF       = 2;
    localparam int APB_AW_DEF      = 2;
    localparam int APB_DW_DEF      = 2;
    localparam int APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past last winner.
// Pointer holds the first index to consider and moves only on advance.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         pclk,
    input  logic         preset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  hi;
    logic [N-1:0]  src;

    // Prefer requesters at or above the pointer, else wrap to the lowest.
    always_comb begin
        hi = '0;
        for (int k = 0; k < N; k++) begin
            hi[k] = req[k] && (k >= int'(ptr_q));
        end
        src   = (|hi) ? hi : req;
        grant = '0;
        ptr_d = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (src[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                ptr_d    = (k == N - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    // Pointer register, requester 0 first after reset.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared among N requesters with round-robin grant,
// SETUP/ACCESS sequencing, wait-state timeout and per-requester response.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int N       = APB_N_DEF,
    parameter int AW      = APB_AW_DEF,
    parameter int DW      = APB_DW_DEF,
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic            pclk,
    input  logic            preset_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_write,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_error,
    output logic [AW-1:0]   paddr,
    output logic [DW-1:0]   pwdata,
    output logic            pwrite,
    output logic            pselx,
    output logic            penable,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslave_error,
    output logic            busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    apb_state_e    state_q;
    logic [CW-1:0] wait_q;
    logic [N-1:0]  owner_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic          pwrite_q, pselx_q, penable_q;
    logic [N-1:0]  rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_error_q;

    logic [N-1:0]  arb_req, grant;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_write;
    logic          done, abort, open;

    assign done  = (state_q == APB_ACCESS) && pready;
    assign abort = (TIMEOUT != 0) && (state_q == APB_ACCESS) && !pready
                   && ((wait_q + CW'(1)) == TO_V);
    assign open  = (state_q == APB_IDLE) || done;

    assign arb_req   = open ? req_valid : '0;
    assign req_ready = grant;

    rr_arbiter #(.N(N)) u_arb (
        .pclk     (pclk),
        .preset_n (preset_n),
        .req      (arb_req),
        .advance  (|grant),
        .grant    (grant)
    );

    // Select the winner's request fields from the flattened inputs.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                sel_addr  = req_addr[k*AW +: AW];
                sel_wdata = req_wdata[k*DW +: DW];
                sel_write = req_write[k];
            end
        end
    end

    // Phase machine, wait counter, latched transfer and response pulse.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= APB_IDLE;
            wait_q      <= '0;
            owner_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (|grant) begin
                owner_q  <= grant;
                paddr_q  <= sel_addr;
                pwdata_q <= sel_wdata;
                pwrite_q <= sel_write;
            end
            unique case (state_q)
                APB_IDLE: begin
                    if (|grant) begin
                        state_q   <= APB_SETUP;
                        pselx_q   <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                APB_SETUP: begin
                    state_q   <= APB_ACCESS;
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                end
                APB_ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_error_q <= pslave_error;
                        wait_q      <= '0;
                        penable_q   <= 1'b0;
                        if (|grant) begin
                            state_q <= APB_SETUP;
                            pselx_q <= 1'b1;
                        end else begin
                            state_q <= APB_IDLE;
                            pselx_q <= 1'b0;
                        end
                    end else if (abort) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b1;
                        wait_q      <= '0;
                        state_q     <= APB_IDLE;
                        pselx_q     <= 1'b0;
                        penable_q   <= 1'b0;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                default: state_q <= APB_IDLE;
            endcase
        end
    end

    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign busy      = (state_q != APB_IDLE);

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

APB master controller that shares a single APB bus (`paddr`, `pwdata`, `pwrite`, `pselx`, `penable`) among N requesters. It picks a requester by round-robin and runs the SETUP/ACCESS phase sequence. It waits on `pready` with a bounded wait-state timeout and returns `prdata`/`pslave_error` to the requester that issued the transfer. It sits between the testbench/system-side request agents and the existing APB interface signals.

## Interface
Parameters:
- `N` — default 2 — number of requesters (≥1).
- `AW` — default 2 — address width (matches `paddr`).
- `DW` — default 2 — data width (matches `pwdata`/`prdata`).
- `TIMEOUT` — default 16 — maximum ACCESS cycles with `pready` low before abort. A value of 0 disables the timeout.

Ports:
- `pclk` — in — 1 — clock; everything is sampled on the rising edge.
- `preset_n` — in — 1 — reset, asynchronous assert, active low.
- `req_valid` — in — N — request pending, one bit per requester.
- `req_write` — in — N — 1 = write, 0 = read, per requester.
- `req_addr` — in — N*AW — flattened addresses; requester i occupies `[i*AW +: AW]`.
- `req_wdata` — in — N*DW — flattened write data, same packing.
- `req_ready` — out — N — one-hot; a request is accepted in a cycle where `req_valid[i] && req_ready[i]`.
- `rsp_valid` — out — N — one-hot, single-cycle completion pulse.
- `rsp_rdata` — out — DW — read data, valid while `rsp_valid` is nonzero.
- `rsp_error` — out — 1 — slave error or timeout, valid with `rsp_valid`.
- `paddr` / `pwdata` / `pwrite` / `pselx` / `penable` — out — AW / DW / 1 / 1 / 1 — APB master outputs.
- `prdata` / `pready` / `pslave_error` — in — DW / 1 / 1 — APB slave returns.
- `busy` — out — 1 — high in SETUP or ACCESS.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `pselx` = 0, `penable` = 0.
  - If any `req_valid` is set, the arbiter grants winner w: `req_ready[w]` = 1 (combinational), and w's addr/wdata/write are latched into the APB output registers. Next state is SETUP.
- SETUP: `pselx` = 1, `penable` = 0. Next state is ACCESS unconditionally.
- ACCESS: `pselx` = 1, `penable` = 1. `paddr`, `pwdata` and `pwrite` are held stable.
  - `pready` = 1 completes the transfer:
    - `prdata` and `pslave_error` are captured.
    - `rsp_valid[w]` pulses on the next cycle.
    - The wait counter clears.
  - On the completion cycle the arbiter runs again. If any `req_valid` is set, the new winner gets `req_ready` that cycle and the FSM goes directly to SETUP (back-to-back). Otherwise it goes to IDLE.
  - `pready` = 0: the wait counter increments. If `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT`, the transfer aborts:
    - next state is IDLE, with `pselx` and `penable` dropped;
    - `rsp_valid[w]` = 1, `rsp_error` = 1, `rsp_rdata` = 0.
- Arbitration:
  - Round-robin, one grant per transfer.
  - The search starts at (last winner + 1) mod N.
  - The pointer updates only on grant.
- `rsp_rdata` returns the captured `prdata` for reads and 0 for writes. `rsp_error` = `pslave_error` at completion.
- The requester may change its `req_*` inputs after acceptance. The latched copy drives the bus.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - FSM goes to IDLE; the pointer points to requester 0 (highest priority at start).
  - Outputs reset to: `pselx` = 0, `penable` = 0, `paddr` = 0, `pwdata` = 0, `pwrite` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0, `busy` = 0, wait counter = 0.
  - A reset mid-transfer discards the transfer; no response is issued.
- Latency, zero wait states:
  - Accept at cycle 0.
  - SETUP at cycle 1.
  - ACCESS at cycle 2, with `pready` sampled high.
  - `rsp_valid` at cycle 3.
- Back-to-back transfers: a new SETUP begins the cycle after ACCESS completes, i.e. 2 cycles per transfer with no IDLE cycle in between.
- `req_ready` is never asserted in SETUP, or in ACCESS before completion.
- Timeout: the abort response appears after exactly `TIMEOUT` low-`pready` ACCESS cycles plus 1.
- If `pready` rises in the same cycle the counter hits `TIMEOUT`, the transfer completes normally; `pready` wins.
- If a requester's `req_valid` drops before grant, it is simply not considered. There is no error.

## Structure
- Package `apb_pkg`:
  - `typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e`;
  - default width localparams.
- Sub-module `rr_arbiter #(N)`:
  - inputs: `req[N]`, `advance`;
  - output: one-hot `grant[N]`;
  - owns the pointer register; same clock and reset.
- The top level holds the FSM, wait counter, latched transfer and response registers.

## Test plan
- Single write, N=2: req0 addr=2 wdata=3, `pready` tied 1 → accepted cycle 0; `pselx` = 1 cycles 1–2; `penable` = 1 cycle 2 only; `rsp_valid` = 2'b01 at cycle 3 with `rsp_error` = 0.
- Read with 3 wait states: req1 addr=1, `pready` high on the 4th ACCESS cycle, `prdata` = 2 → `rsp_valid` = 2'b10, `rsp_rdata` = 2; `paddr` stable throughout.
- Contention: req0 and req1 held continuously → grant order 0, 1, 0, 1; back-to-back SETUP with no IDLE between transfers.
- Slave error: `pslave_error` = 1 with `pready` → `rsp_error` = 1 for that response only.
- Timeout, `TIMEOUT` = 4: `pready` held 0 → abort after 4 ACCESS cycles; `rsp_error` = 1, `rsp_rdata` = 0; FSM returns to IDLE.
- Reset in ACCESS: assert `preset_n` = 0 mid-wait → `pselx` and `penable` drop immediately; no `rsp_valid`; after reset the first grant goes to requester 0.
